mux_scan_reg: RTL and testbench

Parametrised, registered N-channel data selector with manual and auto-scan modes. It generalises the team's 4-bit 2:1 registered mux to WIDTH-bit data and NCH channels. It adds a dwell-timed round-robin scan mode, so one downstream consumer can sample several sources in turn without an external sequencer. It sits between the source registers and the downstream sampling logic, in the same clock domain.

---
 rtl/mux_scan_reg.sv | 76 +++++++
 tb/tb_mux_scan_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// Registered N-channel data selector with manual select and dwell-timed
// round-robin auto-scan; y and ch always name the same channel.
module mux_scan_reg #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned DWELL = 8,
  localparam int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] d,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      ch,
  output logic                 ch_change,
  output logic                 scan_wrap
);

  localparam int unsigned CNTW = $clog2(DWELL) + 1;

  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_next_c;
  logic [SELW-1:0]  ch_next_c;
  logic             wrap_next_c;
  logic [WIDTH-1:0] y_next_c;
  logic [WIDTH-1:0] chan [NCH];

  // Unpack the channel bus so the output mux indexes whole channels
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = d[k*WIDTH +: WIDTH];
  end

  // Next channel / dwell counter; wrap is explicit so odd NCH stays legal
  always_comb begin
    ch_next_c   = ch;
    cnt_next_c  = '0;
    wrap_next_c = 1'b0;
    if (!mode) begin
      if (32'(sel) < NCH) ch_next_c = sel;
    end else if (32'(cnt) == DWELL - 32'd1) begin
      if (32'(ch) == NCH - 32'd1) begin
        ch_next_c   = '0;
        wrap_next_c = 1'b1;
      end else begin
        ch_next_c = ch + SELW'(1);
      end
    end else begin
      cnt_next_c = cnt + CNTW'(1);
    end
  end

  assign y_next_c = chan[ch_next_c];

  // Output and state registers; en low freezes state and drops the pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y         <= '0;
      ch        <= '0;
      cnt       <= '0;
      ch_change <= 1'b0;
      scan_wrap <= 1'b0;
    end else if (en) begin
      y         <= y_next_c;
      ch        <= ch_next_c;
      cnt       <= cnt_next_c;
      ch_change <= (ch_next_c != ch);
      scan_wrap <= wrap_next_c;
    end else begin
      ch_change <= 1'b0;
      scan_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: NCH=4/DWELL=4 and NCH=3/DWELL=2 instances
// share stimulus; an elapsed-count model predicts each cycle's outputs.
module tb_mux_scan_reg;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] ch;
    logic       chg;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] d;

  logic [3:0] y_a, y_b;
  logic [1:0] ch_a, ch_b;
  logic       chg_a, chg_b, wrap_a, wrap_b;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  exp_t q [2][$];

  // Model state: base channel at mode-1 entry and enabled mode-1 edges since
  int m_base [2];
  int m_el   [2];
  int m_cur  [2];
  logic [3:0] m_y [2];

  mux_scan_reg #(.WIDTH(4), .NCH(4), .DWELL(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .d(d),
    .y(y_a), .ch(ch_a), .ch_change(chg_a), .scan_wrap(wrap_a));

  mux_scan_reg #(.WIDTH(4), .NCH(3), .DWELL(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .d(d[11:0]),
    .y(y_b), .ch(ch_b), .ch_change(chg_b), .scan_wrap(wrap_b));

  always #5 clk = ~clk;

  // Reference model: channel = (base + elapsed/DWELL) mod NCH in auto-scan
  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      int nch, dw, nw;
      exp_t e;
      nch = (i == 0) ? 4 : 3;
      dw  = (i == 0) ? 4 : 2;
      if (!reset) begin
        m_base[i] = 0; m_el[i] = 0; m_cur[i] = 0; m_y[i] = 4'd0;
        if (clk) begin
          e = '{y: 4'd0, ch: 2'd0, chg: 1'b0, wrap: 1'b0};
          q[i].push_back(e);
          started = 1'b1;
        end
      end else if (!en) begin
        e = '{y: m_y[i], ch: 2'(m_cur[i]), chg: 1'b0, wrap: 1'b0};
        q[i].push_back(e);
      end else begin
        if (!mode) begin
          nw = (int'(sel) < nch) ? int'(sel) : m_cur[i];
          m_base[i] = nw;
          m_el[i]   = 0;
        end else begin
          m_el[i] = m_el[i] + 1;
          nw = (m_base[i] + m_el[i] / dw) % nch;
        end
        e.y    = d[nw*4 +: 4];
        e.ch   = 2'(nw);
        e.chg  = (nw != m_cur[i]);
        e.wrap = mode && (nw != m_cur[i]) && (nw == 0);
        q[i].push_back(e);
        m_cur[i] = nw;
        m_y[i]   = e.y;
      end
    end
  end

  // Monitor: one expected entry per instance per cycle
  always @(negedge clk) begin
    exp_t act [2];
    act[0] = '{y: y_a, ch: ch_a, chg: chg_a, wrap: wrap_a};
    act[1] = '{y: y_b, ch: ch_b, chg: chg_b, wrap: wrap_b};
    for (int i = 0; i < 2; i++) begin
      if (q[i].size() > 0) begin
        exp_t ex;
        ex = q[i].pop_front();
        checks++;
        if (act[i] !== ex) begin
          errors++;
          $display("FAIL out%0d t=%0t: got y=%0d ch=%0d chg=%b wrap=%b, want y=%0d ch=%0d chg=%b wrap=%b",
                   i, $time, act[i].y, act[i].ch, act[i].chg, act[i].wrap,
                   ex.y, ex.ch, ex.chg, ex.wrap);
        end
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL underflow%0d t=%0t: no expected entry", i, $time);
      end
    end
  end

  task automatic drive(input logic e_v, input logic m_v, input logic [1:0] s_v,
                       input logic [15:0] d_v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      en = e_v; mode = m_v; sel = s_v; d = d_v;
    end
  endtask

  // Assert reset between edges and check that both outputs clear at once
  task automatic async_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({y_a, ch_a, chg_a, wrap_a, y_b, ch_b, chg_b, wrap_b} !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got a=%h/%0d b=%h/%0d, want 0/0", y_a, ch_a, y_b, ch_b);
    end
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0; d = 16'h8421;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    // Manual select, then hold, then out-of-range sel on the 3-channel unit
    drive(1'b1, 1'b0, 2'd2, 16'h8421, 3);
    drive(1'b1, 1'b0, 2'd3, 16'h8421, 2);
    drive(1'b1, 1'b0, 2'd0, 16'h8421, 1);
    // Full auto-scan rotation plus one
    drive(1'b1, 1'b1, 2'd0, 16'h8421, 6);
    drive(1'b0, 1'b1, 2'd0, 16'h8421, 5);
    drive(1'b1, 1'b1, 2'd0, 16'h8421, 14);
    // Mode switches mid-scan
    drive(1'b1, 1'b0, 2'd1, 16'h8421, 1);
    drive(1'b1, 1'b1, 2'd1, 16'h8421, 6);
    // Data tracking on a fixed channel
    drive(1'b1, 1'b0, 2'd1, 16'h8421, 2);
    drive(1'b1, 1'b0, 2'd1, 16'h0F50, 2);
    drive(1'b1, 1'b1, 2'd1, 16'h8421, 5);
    async_reset();
    drive(1'b1, 1'b1, 2'd0, 16'h8421, 10);
    // Random phase
    for (int n = 0; n < 3000; n++) begin
      logic e_v, m_v;
      logic [15:0] d_v;
      e_v = ($urandom_range(0, 7) != 0);
      m_v = ($urandom_range(0, 19) == 0) ? ~mode : mode;
      d_v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : d;
      if ($urandom_range(0, 299) == 0) async_reset();
      drive(e_v, m_v, 2'($urandom), d_v, 1);
    end
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
